// File: rtl/branch_predict_unit_pkg.sv
// Shared branch-unit definitions: branch type encodings and counter reset helpers.
// Pure declarations; no logic, no latency, no backpressure.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_BGEZ = 3'd6,
        BR_J    = 3'd7
    } br_type_e;

    localparam int STAT_W = 32;

    // Weakly not-taken: one below the midpoint of the counter range.
    function automatic int unsigned ctr_rst_val(input int unsigned cnt_w);
        return (32'd1 << (cnt_w - 1)) - 32'd1;
    endfunction

    function automatic logic is_cond_branch(input br_type_e t);
        return (t != BR_NONE) && (t != BR_J);
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch/decode-side bundle of the branch unit: prediction lookup, resolve inputs, redirect and stats.
// Wires only; no latency, no backpressure.
interface branch_predict_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] f_pc;
    logic             f_pred_taken;
    logic             d_valid;
    logic             d_stall;
    logic [2:0]       d_branch;
    logic [WIDTH-1:0] d_pc;
    logic             d_pred_taken;
    logic [15:0]      d_imm;
    logic [WIDTH-1:0] d_rd1;
    logic [WIDTH-1:0] d_rd2;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             flush;
    logic [31:0]      stat_branches;
    logic [31:0]      stat_mispred;

    modport master (
        output f_pc, d_valid, d_stall, d_branch, d_pc, d_pred_taken, d_imm, d_rd1, d_rd2,
        input  f_pred_taken, redirect, redirect_pc, flush, stat_branches, stat_mispred
    );

    modport slave (
        input  f_pc, d_valid, d_stall, d_branch, d_pc, d_pred_taken, d_imm, d_rd1, d_rd2,
        output f_pred_taken, redirect, redirect_pc, flush, stat_branches, stat_mispred
    );
endinterface

// File: rtl/branch_predict_unit_sat_counter.sv
// Saturating up/down counter with synchronous active-low reset and a clear to RST_VAL.
// Value changes one edge after inc/dec; inc and dec together hold; never stalls.
module sat_counter #(
    parameter int           W       = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = RST_VAL;
        end else if (inc && !dec && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/branch_predict_unit.sv
// PHT-based branch predictor (bimodal or gshare) plus D-stage resolver with redirect/flush and stats.
// Prediction and redirect are combinational; PHT/GHR/stats update one edge after resolve; a stall blocks all effects.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int IDX_W      = 6,
    parameter int CNT_W      = 2,
    parameter int HIST_W     = 0,
    parameter int PREDICT_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    branch_predict_unit_if.slave bus
);

    localparam int               NUM_ENT = 1 << IDX_W;
    localparam int               GHR_W   = (HIST_W > 0) ? HIST_W : 1;
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(ctr_rst_val(CNT_W));

    generate
        if (HIST_W > IDX_W) begin : g_bad_hist
            $error("HIST_W must not exceed IDX_W");
        end
    endgenerate

    logic [CNT_W-1:0] pht [NUM_ENT];
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;
    logic [IDX_W-1:0] ghr_ext;
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] d_idx;

    br_type_e         br;
    logic             resolve;
    logic             taken;
    logic             mispred;
    logic             pht_upd;
    logic             rd1_neg;
    logic             rd1_zero;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] fallthrough;
    logic [WIDTH-1:0] target;

    generate
        if (HIST_W > 0) begin : g_gshare
            assign ghr_ext = IDX_W'(ghr_q);
        end else begin : g_bimodal
            assign ghr_ext = '0;
        end
    endgenerate

    // F and D both hash against the current (pre-update) GHR.
    always_comb begin
        f_idx = bus.f_pc[IDX_W+1:2] ^ ghr_ext;
        d_idx = bus.d_pc[IDX_W+1:2] ^ ghr_ext;
    end

    always_comb begin
        br       = br_type_e'(bus.d_branch);
        resolve  = bus.d_valid && !bus.d_stall && (br != BR_NONE);
        rd1_neg  = bus.d_rd1[WIDTH-1];
        rd1_zero = (bus.d_rd1 == '0);
        taken    = 1'b0;
        unique case (br)
            BR_NONE: taken = 1'b0;
            BR_BEQ:  taken = (bus.d_rd1 == bus.d_rd2);
            BR_BNE:  taken = (bus.d_rd1 != bus.d_rd2);
            BR_BLEZ: taken = rd1_neg || rd1_zero;
            BR_BGTZ: taken = !rd1_neg && !rd1_zero;
            BR_BLTZ: taken = rd1_neg;
            BR_BGEZ: taken = !rd1_neg;
            BR_J:    taken = 1'b1;
        endcase
        mispred = resolve && (taken != bus.d_pred_taken);
        pht_upd = (PREDICT_EN != 0) && resolve && is_cond_branch(br);
    end

    always_comb begin
        imm_ext     = {{(WIDTH-16){bus.d_imm[15]}}, bus.d_imm};
        fallthrough = bus.d_pc + WIDTH'(4);
        target      = fallthrough + (imm_ext << 2);
    end

    assign bus.redirect     = mispred;
    assign bus.flush        = mispred;
    assign bus.redirect_pc  = (mispred && !taken) ? fallthrough : target;
    assign bus.f_pred_taken = (PREDICT_EN != 0) ? pht[f_idx][CNT_W-1] : 1'b0;

    always_comb begin
        ghr_d = ghr_q;
        if (pht_upd) begin
            ghr_d = GHR_W'({ghr_q, taken});
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    generate
        for (genvar i = 0; i < NUM_ENT; i++) begin : g_pht
            logic hit;
            assign hit = pht_upd && (d_idx == IDX_W'(i));
            sat_counter #(
                .W       (CNT_W),
                .RST_VAL (CNT_RST)
            ) u_ctr (
                .clk   (clk),
                .rst_n (reset),
                .clr   (1'b0),
                .inc   (hit && taken),
                .dec   (hit && !taken),
                .q     (pht[i])
            );
        end
    endgenerate

    sat_counter #(
        .W       (STAT_W),
        .RST_VAL ('0)
    ) u_stat_branches (
        .clk   (clk),
        .rst_n (reset),
        .clr   (1'b0),
        .inc   (resolve),
        .dec   (1'b0),
        .q     (bus.stat_branches)
    );

    sat_counter #(
        .W       (STAT_W),
        .RST_VAL ('0)
    ) u_stat_mispred (
        .clk   (clk),
        .rst_n (reset),
        .clr   (1'b0),
        .inc   (mispred),
        .dec   (1'b0),
        .q     (bus.stat_mispred)
    );

endmodule

// File: tb/tb_branch_predict_unit.sv
// Drives three configurations (bimodal, gshare HIST_W=2, static not-taken) with one stimulus stream
// and compares each against a per-configuration behavioural model.
module tb_branch_predict_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] f_pc, d_pc, d_rd1, d_rd2;
    logic        d_valid, d_stall, d_pred_taken;
    logic [2:0]  d_branch;
    logic [15:0] d_imm;

    branch_predict_unit_if #(.WIDTH(32)) bus_bi ();
    branch_predict_unit_if #(.WIDTH(32)) bus_gh ();
    branch_predict_unit_if #(.WIDTH(32)) bus_np ();

    assign bus_bi.f_pc = f_pc;       assign bus_gh.f_pc = f_pc;       assign bus_np.f_pc = f_pc;
    assign bus_bi.d_valid = d_valid; assign bus_gh.d_valid = d_valid; assign bus_np.d_valid = d_valid;
    assign bus_bi.d_stall = d_stall; assign bus_gh.d_stall = d_stall; assign bus_np.d_stall = d_stall;
    assign bus_bi.d_branch = d_branch; assign bus_gh.d_branch = d_branch; assign bus_np.d_branch = d_branch;
    assign bus_bi.d_pc = d_pc;       assign bus_gh.d_pc = d_pc;       assign bus_np.d_pc = d_pc;
    assign bus_bi.d_pred_taken = d_pred_taken; assign bus_gh.d_pred_taken = d_pred_taken;
    assign bus_np.d_pred_taken = d_pred_taken;
    assign bus_bi.d_imm = d_imm;     assign bus_gh.d_imm = d_imm;     assign bus_np.d_imm = d_imm;
    assign bus_bi.d_rd1 = d_rd1;     assign bus_gh.d_rd1 = d_rd1;     assign bus_np.d_rd1 = d_rd1;
    assign bus_bi.d_rd2 = d_rd2;     assign bus_gh.d_rd2 = d_rd2;     assign bus_np.d_rd2 = d_rd2;

    branch_predict_unit #(.HIST_W(0), .PREDICT_EN(1)) u_bi (.clk(clk), .reset(reset), .bus(bus_bi));
    branch_predict_unit #(.HIST_W(2), .PREDICT_EN(1)) u_gh (.clk(clk), .reset(reset), .bus(bus_gh));
    branch_predict_unit #(.HIST_W(0), .PREDICT_EN(0)) u_np (.clk(clk), .reset(reset), .bus(bus_np));

    logic        obs_pred [3];
    logic        obs_redir[3];
    logic        obs_flush[3];
    logic [31:0] obs_rpc  [3];
    logic [31:0] obs_br   [3];
    logic [31:0] obs_mis  [3];
    assign obs_pred[0] = bus_bi.f_pred_taken; assign obs_pred[1] = bus_gh.f_pred_taken;
    assign obs_pred[2] = bus_np.f_pred_taken;
    assign obs_redir[0] = bus_bi.redirect; assign obs_redir[1] = bus_gh.redirect;
    assign obs_redir[2] = bus_np.redirect;
    assign obs_flush[0] = bus_bi.flush; assign obs_flush[1] = bus_gh.flush; assign obs_flush[2] = bus_np.flush;
    assign obs_rpc[0] = bus_bi.redirect_pc; assign obs_rpc[1] = bus_gh.redirect_pc;
    assign obs_rpc[2] = bus_np.redirect_pc;
    assign obs_br[0] = bus_bi.stat_branches; assign obs_br[1] = bus_gh.stat_branches;
    assign obs_br[2] = bus_np.stat_branches;
    assign obs_mis[0] = bus_bi.stat_mispred; assign obs_mis[1] = bus_gh.stat_mispred;
    assign obs_mis[2] = bus_np.stat_mispred;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural reference model ----------------
    int     mpht[3][64];
    int     mghr[3];
    longint mbr [3];
    longint mmis[3];

    function automatic int hw(int c);
        return (c == 1) ? 2 : 0;
    endfunction

    function automatic bit pe(int c);
        return c != 2;
    endfunction

    function automatic int m_idx(int c, logic [31:0] pc);
        int base;
        base = int'(pc[7:2]);
        return (hw(c) > 0) ? (base ^ mghr[c]) : base;
    endfunction

    function automatic bit m_taken(logic [2:0] br, logic [31:0] a, logic [31:0] b);
        int sa;
        sa = $signed(a);
        case (br)
            3'd1: return a == b;
            3'd2: return a != b;
            3'd3: return sa <= 0;
            3'd4: return sa > 0;
            3'd5: return sa < 0;
            3'd6: return sa >= 0;
            3'd7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_resolve();
        return d_valid && !d_stall && (d_branch != 3'd0);
    endfunction

    function automatic bit m_mis();
        return m_resolve() && (m_taken(d_branch, d_rd1, d_rd2) != d_pred_taken);
    endfunction

    function automatic logic [31:0] m_rpc();
        int off;
        off = $signed(d_imm);
        if (m_taken(d_branch, d_rd1, d_rd2)) return d_pc + 32'd4 + 32'(off * 4);
        return d_pc + 32'd4;
    endfunction

    function automatic bit m_fpred(int c);
        return pe(c) ? (mpht[c][m_idx(c, f_pc)] >= 2) : 1'b0;
    endfunction

    task automatic model_edge();
        bit t;
        int i;
        if (!reset) begin
            for (int c = 0; c < 3; c++) begin
                for (int e = 0; e < 64; e++) mpht[c][e] = 1;
                mghr[c] = 0; mbr[c] = 0; mmis[c] = 0;
            end
        end else if (m_resolve()) begin
            t = m_taken(d_branch, d_rd1, d_rd2);
            for (int c = 0; c < 3; c++) begin
                if (mbr[c] < 64'hFFFF_FFFF) mbr[c]++;
                if (t != d_pred_taken && mmis[c] < 64'hFFFF_FFFF) mmis[c]++;
                if (pe(c) && d_branch != 3'd7) begin
                    i = m_idx(c, d_pc);
                    if (t && mpht[c][i] < 3) mpht[c][i]++;
                    if (!t && mpht[c][i] > 0) mpht[c][i]--;
                    if (hw(c) > 0) mghr[c] = ((mghr[c] << 1) | int'(t)) & ((1 << hw(c)) - 1);
                end
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_valid = 1'b0; d_stall = 1'b0; d_branch = 3'd0; d_pc = 32'h0;
        d_pred_taken = 1'b0; d_imm = 16'h0; d_rd1 = 32'h0; d_rd2 = 32'h0;
    endtask

    task automatic set_br(input logic [2:0] br, input logic [31:0] pc, input logic [31:0] a,
                          input logic [31:0] b, input logic pred, input logic [15:0] imm);
        d_valid = 1'b1; d_stall = 1'b0; d_branch = br; d_pc = pc;
        d_rd1 = a; d_rd2 = b; d_pred_taken = pred; d_imm = imm;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        tick();
        tick();
        reset = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        f_pc = 32'h3000;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs_pred[c] !== 1'b0) begin
                errors++; $display("FAIL reset_pred cfg%0d got %0b want 0", c, obs_pred[c]);
            end
            checks++;
            if (obs_br[c] !== 32'd0 || obs_mis[c] !== 32'd0) begin
                errors++; $display("FAIL reset_stats cfg%0d got %0d/%0d want 0/0", c, obs_br[c], obs_mis[c]);
            end
        end
        checks++;
        if (obs_redir[0] !== 1'b0 || obs_flush[0] !== 1'b0) begin
            errors++; $display("FAIL reset_redirect got %0b/%0b want 0/0", obs_redir[0], obs_flush[0]);
        end
        tick();
    endtask

    task automatic test_mispredict();
        f_pc = 32'h3000;
        set_br(3'd1, 32'h3000, 32'd5, 32'd5, 1'b0, 16'd3);
        @(negedge clk);
        checks++;
        if (obs_redir[0] !== 1'b1 || obs_flush[0] !== 1'b1 || obs_rpc[0] !== 32'h3010) begin
            errors++; $display("FAIL mispred_redirect got %0b/%0b/%h want 1/1/00003010",
                               obs_redir[0], obs_flush[0], obs_rpc[0]);
        end
        checks++;
        if (obs_pred[0] !== 1'b0) begin
            errors++; $display("FAIL read_during_write got %0b want 0 (pre-update)", obs_pred[0]);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (obs_pred[0] !== 1'b1) begin
            errors++; $display("FAIL mispred_pred_next got %0b want 1", obs_pred[0]);
        end
        checks++;
        if (obs_pred[1] !== m_fpred(1) || obs_pred[2] !== 1'b0) begin
            errors++; $display("FAIL mispred_pred_cfgs got %0b/%0b want %0b/0", obs_pred[1], obs_pred[2], m_fpred(1));
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs_br[c] !== 32'd1 || obs_mis[c] !== 32'd1) begin
                errors++; $display("FAIL mispred_stats cfg%0d got %0d/%0d want 1/1", c, obs_br[c], obs_mis[c]);
            end
        end
        tick();
    endtask

    task automatic test_saturate();
        f_pc = 32'h3000;
        for (int k = 0; k < 3; k++) begin
            set_br(3'd1, 32'h3000, 32'd5, 32'd5, 1'b1, 16'd3);
            @(negedge clk);
            checks++;
            if (obs_redir[0] !== 1'b0) begin
                errors++; $display("FAIL sat_no_redirect k%0d got %0b want 0", k, obs_redir[0]);
            end
            tick();
        end
        set_br(3'd1, 32'h3000, 32'd5, 32'd6, 1'b1, 16'd3);
        @(negedge clk);
        checks++;
        if (obs_redir[0] !== 1'b1 || obs_rpc[0] !== 32'h3004) begin
            errors++; $display("FAIL sat_nt_redirect got %0b/%h want 1/00003004", obs_redir[0], obs_rpc[0]);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (obs_pred[0] !== 1'b1) begin
            errors++; $display("FAIL sat_still_taken got %0b want 1", obs_pred[0]);
        end
        checks++;
        if (obs_pred[1] !== m_fpred(1)) begin
            errors++; $display("FAIL sat_gshare_pred got %0b want %0b", obs_pred[1], m_fpred(1));
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs_br[c] !== 32'd5 || obs_mis[c] !== 32'd2) begin
                errors++; $display("FAIL sat_stats cfg%0d got %0d/%0d want 5/2", c, obs_br[c], obs_mis[c]);
            end
        end
        tick();
    endtask

    task automatic test_signed();
        set_br(3'd5, 32'h4000, 32'h8000_0000, 32'h0, 1'b1, 16'hFFFF);
        @(negedge clk);
        checks++;
        if (obs_redir[0] !== 1'b0) begin
            errors++; $display("FAIL bltz_min got %0b want 0", obs_redir[0]);
        end
        tick();
        set_br(3'd6, 32'h4000, 32'h8000_0000, 32'h0, 1'b1, 16'hFFFF);
        @(negedge clk);
        checks++;
        if (obs_redir[0] !== 1'b1 || obs_rpc[0] !== 32'h4004) begin
            errors++; $display("FAIL bgez_min got %0b/%h want 1/00004004", obs_redir[0], obs_rpc[0]);
        end
        tick();
        set_br(3'd3, 32'h4000, 32'h0, 32'h0, 1'b0, 16'hFFFE);
        @(negedge clk);
        checks++;
        if (obs_redir[0] !== 1'b1 || obs_rpc[0] !== 32'h3FFC) begin
            errors++; $display("FAIL blez_zero got %0b/%h want 1/00003ffc", obs_redir[0], obs_rpc[0]);
        end
        tick();
        set_br(3'd4, 32'h4000, 32'h0, 32'h0, 1'b1, 16'h0010);
        @(negedge clk);
        checks++;
        if (obs_redir[0] !== 1'b1 || obs_rpc[0] !== 32'h4004) begin
            errors++; $display("FAIL bgtz_zero got %0b/%h want 1/00004004", obs_redir[0], obs_rpc[0]);
        end
        tick();
        idle();
    endtask

    task automatic test_stall();
        longint b0, m0;
        b0 = mbr[0]; m0 = mmis[0];
        set_br(3'd1, 32'h5000, 32'd7, 32'd7, 1'b0, 16'd2);
        d_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs_redir[0] !== 1'b0 || obs_flush[0] !== 1'b0 || obs_br[0] !== 32'(b0)) begin
                errors++; $display("FAIL stall_quiet k%0d got %0b/%0b/%0d want 0/0/%0d",
                                   k, obs_redir[0], obs_flush[0], obs_br[0], b0);
            end
            tick();
        end
        d_stall = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_redir[0] !== 1'b1 || obs_rpc[0] !== 32'h500C) begin
            errors++; $display("FAIL stall_release got %0b/%h want 1/0000500c", obs_redir[0], obs_rpc[0]);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (obs_br[0] !== 32'(b0 + 1) || obs_mis[0] !== 32'(m0 + 1)) begin
            errors++; $display("FAIL stall_stats got %0d/%0d want %0d/%0d", obs_br[0], obs_mis[0], b0 + 1, m0 + 1);
        end
        tick();
    endtask

    task automatic test_ghr();
        do_reset();
        set_br(3'd1, 32'h300C, 32'd1, 32'd1, 1'b1, 16'd0);
        tick();
        set_br(3'd1, 32'h3008, 32'd1, 32'd1, 1'b1, 16'd0);
        tick();
        idle();
        f_pc = 32'h3000;
        @(negedge clk);
        checks++;
        if (obs_pred[1] !== 1'b1 || obs_pred[0] !== 1'b0) begin
            errors++; $display("FAIL ghr_idx3 got gshare %0b bimodal %0b want 1/0", obs_pred[1], obs_pred[0]);
        end
        f_pc = 32'h300C;
        @(negedge clk);
        checks++;
        if (obs_pred[1] !== 1'b0 || obs_pred[0] !== 1'b1) begin
            errors++; $display("FAIL ghr_idx0 got gshare %0b bimodal %0b want 0/1", obs_pred[1], obs_pred[0]);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] pool[6];
        logic        e_mis;
        logic [31:0] e_rpc;
        for (int n = 0; n < 600; n++) begin
            pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF;
            pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF; pool[5] = $urandom;
            reset        = ($urandom_range(0, 80) != 0);
            d_valid      = ($urandom_range(0, 3) != 0);
            d_stall      = ($urandom_range(0, 4) == 0);
            d_branch     = 3'($urandom_range(0, 7));
            d_pc         = ($urandom_range(0, 4) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 15) * 4);
            d_rd1        = pool[$urandom_range(0, 5)];
            d_rd2        = ($urandom_range(0, 1) == 0) ? d_rd1 : pool[$urandom_range(0, 5)];
            d_pred_taken = 1'($urandom_range(0, 1));
            d_imm        = 16'($urandom);
            f_pc         = 32'h3000 + 32'($urandom_range(0, 15) * 4);
            @(negedge clk);
            e_mis = m_mis();
            e_rpc = m_rpc();
            checks++;
            if (obs_redir[0] !== e_mis || obs_flush[0] !== e_mis || obs_redir[2] !== e_mis) begin
                errors++; $display("FAIL rnd_redirect n%0d got %0b/%0b/%0b want %0b",
                                   n, obs_redir[0], obs_flush[0], obs_redir[2], e_mis);
            end
            if (e_mis) begin
                checks++;
                if (obs_rpc[0] !== e_rpc || obs_rpc[1] !== e_rpc) begin
                    errors++; $display("FAIL rnd_rpc n%0d got %h/%h want %h", n, obs_rpc[0], obs_rpc[1], e_rpc);
                end
            end
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (obs_pred[c] !== m_fpred(c)) begin
                    errors++; $display("FAIL rnd_pred n%0d cfg%0d got %0b want %0b", n, c, obs_pred[c], m_fpred(c));
                end
                checks++;
                if (obs_br[c] !== 32'(mbr[c]) || obs_mis[c] !== 32'(mmis[c])) begin
                    errors++; $display("FAIL rnd_stats n%0d cfg%0d got %0d/%0d want %0d/%0d",
                                       n, c, obs_br[c], obs_mis[c], mbr[c], mmis[c]);
                end
            end
            tick();
        end
        reset = 1'b1;
        idle();
    endtask

    initial begin
        reset = 1'b0;
        f_pc  = 32'h0;
        idle();
        test_reset();
        test_mispredict();
        test_saturate();
        test_signed();
        test_stall();
        test_ghr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
